// File: rtl/clk_gate_ctrl_if.sv
// Handshake between the clock-gating controller and its gated domain.
// The controller is the slave modport; the domain side (or a bench) is the master.
interface clk_gate_ctrl_if;
    logic busy_i;
    logic req_valid_i;
    logic req_ready_o;
    logic sleep_req_o;
    logic sleep_ack_i;

    modport master (
        output busy_i,
        output req_valid_i,
        output sleep_ack_i,
        input  req_ready_o,
        input  sleep_req_o
    );

    modport slave (
        input  busy_i,
        input  req_valid_i,
        input  sleep_ack_i,
        output req_ready_o,
        output sleep_req_o
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-gating controller for one gated GPU clock domain.
// Detects sustained idleness, runs a sleep req/ack handshake, drops the
// clock-gate enable, and on new work re-enables the clock and holds off
// requesters for WAKE_CYCLES settling cycles.
// Optional macro CLK_GATE_STATS_EN adds a wrapping gated-cycle counter;
// without it gated_cycles_o is tied to zero.
module clk_gate_ctrl #(
    parameter int unsigned IDLE_CNT_W  = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned STATS_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDLE_CNT_W-1:0] idle_thr_i,
    input  logic                  force_on_i,
    clk_gate_ctrl_if.slave        hs,
    output logic                  clk_en_o,
    output logic                  gated_o,
    output logic [STATS_W-1:0]    gated_cycles_o
);

    localparam int unsigned WAKE_W = 4;
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SLEEP_REQ = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } state_t;

    state_t                state_q, state_nxt;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_nxt;
    logic [WAKE_W-1:0]     wake_cnt_q, wake_cnt_nxt;
    logic                  clk_en_nxt, gated_nxt, ready_nxt, sleep_req_nxt;

    logic                  idle;
    logic                  wake_evt;
    logic [IDLE_CNT_W-1:0] thr_m1;

    assign idle     = !hs.busy_i && !hs.req_valid_i && !force_on_i;
    assign wake_evt = hs.req_valid_i || hs.busy_i || force_on_i;
    assign thr_m1   = idle_thr_i - IDLE_CNT_W'(1);

    // State, counters and registered outputs; reset forces the clock on.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            idle_cnt_q     <= '0;
            wake_cnt_q     <= '0;
            clk_en_o       <= 1'b1;
            gated_o        <= 1'b0;
            hs.req_ready_o <= 1'b1;
            hs.sleep_req_o <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            idle_cnt_q     <= idle_cnt_nxt;
            wake_cnt_q     <= wake_cnt_nxt;
            clk_en_o       <= clk_en_nxt;
            gated_o        <= gated_nxt;
            hs.req_ready_o <= ready_nxt;
            hs.sleep_req_o <= sleep_req_nxt;
        end
    end

    // Next-state, counter updates and next output values.
    always_comb begin
        state_nxt    = state_q;
        idle_cnt_nxt = idle_cnt_q;
        wake_cnt_nxt = wake_cnt_q;

        case (state_q)
            RUN: begin
                if (idle_thr_i == '0 || !idle) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt_q >= thr_m1) begin
                    // >= covers a threshold lowered below the running count
                    state_nxt    = SLEEP_REQ;
                    idle_cnt_nxt = '0;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_nxt = idle_cnt_q + IDLE_CNT_W'(1);
                end
            end
            SLEEP_REQ: begin
                idle_cnt_nxt = '0;
                if (!idle) begin
                    state_nxt = RUN;
                end else if (hs.sleep_ack_i) begin
                    state_nxt = GATED;
                end
            end
            GATED: begin
                idle_cnt_nxt = '0;
                if (wake_evt) begin
                    state_nxt    = WAKE;
                    wake_cnt_nxt = WAKE_LOAD;
                end
            end
            WAKE: begin
                idle_cnt_nxt = '0;
                if (wake_cnt_q == '0) begin
                    state_nxt = RUN;
                end else begin
                    wake_cnt_nxt = wake_cnt_q - WAKE_W'(1);
                end
            end
            default: begin
                state_nxt    = RUN;
                idle_cnt_nxt = '0;
                wake_cnt_nxt = '0;
            end
        endcase

        clk_en_nxt    = (state_nxt != GATED);
        gated_nxt     = (state_nxt == GATED);
        ready_nxt     = (state_nxt == RUN) || (state_nxt == SLEEP_REQ);
        sleep_req_nxt = (state_nxt == SLEEP_REQ);
    end

`ifdef CLK_GATE_STATS_EN
    // Count cycles in which the registered gated status is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gated_cycles_o <= '0;
        end else if (gated_o) begin
            gated_cycles_o <= gated_cycles_o + STATS_W'(1);
        end
    end
`else
    assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (WAKE_CYCLES = 2).
module tb_clk_gate_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  thr;
    logic        force_on;
    logic        clk_en;
    logic        gated;
    logic [31:0] gated_cycles;
    logic [31:0] exp_stats;
    int          n_checks;
    int          n_fail;

    clk_gate_ctrl_if cg_if ();

    clk_gate_ctrl #(
        .IDLE_CNT_W (8),
        .WAKE_CYCLES(2),
        .STATS_W    (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .idle_thr_i    (thr),
        .force_on_i    (force_on),
        .hs            (cg_if),
        .clk_en_o      (clk_en),
        .gated_o       (gated),
        .gated_cycles_o(gated_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n active edges, leaving time 1 unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; thr = 8'd0; force_on = 1'b0;
        cg_if.busy_i = 1'b0; cg_if.req_valid_i = 1'b0; cg_if.sleep_ack_i = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (clk_en !== 1'b1 || cg_if.req_ready_o !== 1'b1 || gated !== 1'b0 ||
            cg_if.sleep_req_o !== 1'b0 || gated_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: en=%b rdy=%b gated=%b sreq=%b stats=%0d required 1 1 0 0 0",
                     clk_en, cg_if.req_ready_o, gated, cg_if.sleep_req_o, gated_cycles);
        end
    endtask

    task automatic test_nominal_gate();
        thr = 8'd4;
        tick(3);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_early_sreq: got %b required 0", cg_if.sleep_req_o);
        end
        tick(1);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b1 || clk_en !== 1'b1 || cg_if.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_sreq: sreq=%b en=%b rdy=%b required 1 1 1",
                     cg_if.sleep_req_o, clk_en, cg_if.req_ready_o);
        end
        tick(2);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b1 || clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_hold_sreq: sreq=%b en=%b required 1 1", cg_if.sleep_req_o, clk_en);
        end
        cg_if.sleep_ack_i = 1'b1;
        tick(1);
        cg_if.sleep_ack_i = 1'b0;
        n_checks++;
        if (clk_en !== 1'b0 || gated !== 1'b1 || cg_if.req_ready_o !== 1'b0 ||
            cg_if.sleep_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_gated: en=%b gated=%b rdy=%b sreq=%b required 0 1 0 0",
                     clk_en, gated, cg_if.req_ready_o, cg_if.sleep_req_o);
        end
    endtask

    task automatic test_wake();
        tick(9);
        n_checks++;
        if (gated !== 1'b1 || clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_still_gated: gated=%b en=%b required 1 0", gated, clk_en);
        end
        cg_if.req_valid_i = 1'b1;
        tick(1);
        cg_if.req_valid_i = 1'b0;
        n_checks++;
        if (clk_en !== 1'b1 || cg_if.req_ready_o !== 1'b0 || gated !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_edge: en=%b rdy=%b gated=%b required 1 0 0",
                     clk_en, cg_if.req_ready_o, gated);
        end
        n_checks++;
        if (gated_cycles !== exp_stats) begin
            n_fail++;
            $display("FAIL stats_count: got %0d required %0d", gated_cycles, exp_stats);
        end
        // a new wake event during WAKE must not change the settle time
        cg_if.busy_i = 1'b1;
        tick(1);
        cg_if.busy_i = 1'b0;
        n_checks++;
        if (cg_if.req_ready_o !== 1'b0 || clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL wake_settle: rdy=%b en=%b required 0 1", cg_if.req_ready_o, clk_en);
        end
        tick(1);
        n_checks++;
        if (cg_if.req_ready_o !== 1'b1 || clk_en !== 1'b1 || gated_cycles !== exp_stats) begin
            n_fail++;
            $display("FAIL wake_ready: rdy=%b en=%b stats=%0d required 1 1 %0d",
                     cg_if.req_ready_o, clk_en, gated_cycles, exp_stats);
        end
    endtask

    task automatic test_abort();
        cg_if.busy_i = 1'b1;
        tick(1);
        cg_if.busy_i = 1'b0;
        tick(4);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup_sreq: got %b required 1", cg_if.sleep_req_o);
        end
        cg_if.busy_i = 1'b1;
        cg_if.sleep_ack_i = 1'b1;
        tick(1);
        cg_if.busy_i = 1'b0;
        cg_if.sleep_ack_i = 1'b0;
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b0 || clk_en !== 1'b1 || gated !== 1'b0 ||
            cg_if.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_priority: sreq=%b en=%b gated=%b rdy=%b required 0 1 0 1",
                     cg_if.sleep_req_o, clk_en, gated, cg_if.req_ready_o);
        end
        tick(3);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_restart_early: got %b required 0", cg_if.sleep_req_o);
        end
        tick(1);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart_sreq: got %b required 1", cg_if.sleep_req_o);
        end
        cg_if.busy_i = 1'b1;
        tick(1);
        cg_if.busy_i = 1'b0;
    endtask

    task automatic test_disable_override();
        int sreq_seen;
        thr = 8'd0;
        sreq_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (cg_if.sleep_req_o !== 1'b0) sreq_seen++;
        end
        n_checks++;
        if (sreq_seen != 0) begin
            n_fail++;
            $display("FAIL disable_thr0: sreq seen %0d cycles required 0", sreq_seen);
        end
        thr = 8'd3;
        force_on = 1'b1;
        sreq_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (cg_if.sleep_req_o !== 1'b0) sreq_seen++;
        end
        n_checks++;
        if (sreq_seen != 0) begin
            n_fail++;
            $display("FAIL force_on_hold: sreq seen %0d cycles required 0", sreq_seen);
        end
        force_on = 1'b0;
        tick(2);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL force_release_early: got %b required 0", cg_if.sleep_req_o);
        end
        tick(1);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL force_release_sreq: got %b required 1", cg_if.sleep_req_o);
        end
        cg_if.busy_i = 1'b1;
        tick(1);
        cg_if.busy_i = 1'b0;
    endtask

    task automatic test_thr_change();
        thr = 8'd8;
        tick(5);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL thr8_early: got %b required 0", cg_if.sleep_req_o);
        end
        thr = 8'd3;
        tick(1);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL thr_lowered: got %b required 1", cg_if.sleep_req_o);
        end
        cg_if.busy_i = 1'b1;
        tick(1);
        cg_if.busy_i = 1'b0;
    endtask

    task automatic test_ack_ignored();
        thr = 8'd0;
        cg_if.sleep_ack_i = 1'b1;
        tick(3);
        cg_if.sleep_ack_i = 1'b0;
        n_checks++;
        if (gated !== 1'b0 || clk_en !== 1'b1 || cg_if.sleep_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_in_run: gated=%b en=%b sreq=%b required 0 1 0",
                     gated, clk_en, cg_if.sleep_req_o);
        end
    endtask

    task automatic test_reset_mid_gated();
        thr = 8'd2;
        tick(2);
        cg_if.sleep_ack_i = 1'b1;
        tick(1);
        cg_if.sleep_ack_i = 1'b0;
        tick(3);
        n_checks++;
        if (gated !== 1'b1 || clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_setup_gated: gated=%b en=%b required 1 0", gated, clk_en);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (clk_en !== 1'b1 || cg_if.req_ready_o !== 1'b1 || gated !== 1'b0 ||
            cg_if.sleep_req_o !== 1'b0 || gated_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async: en=%b rdy=%b gated=%b sreq=%b stats=%0d required 1 1 0 0 0",
                     clk_en, cg_if.req_ready_o, gated, cg_if.sleep_req_o, gated_cycles);
        end
        tick(2);
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b0 || clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_run: sreq=%b en=%b required 0 1", cg_if.sleep_req_o, clk_en);
        end
        tick(1);
        n_checks++;
        if (cg_if.sleep_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_sreq: got %b required 1", cg_if.sleep_req_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef CLK_GATE_STATS_EN
        exp_stats = 32'd10;
`else
        exp_stats = 32'd0;
`endif
        test_reset();
        test_nominal_gate();
        test_wake();
        test_abort();
        test_disable_override();
        test_thr_change();
        test_ack_ignored();
        test_reset_mid_gated();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
